minibyte_bus_ctrl: RTL and testbench

- External memory/IO bus sequencer directly downstream of the MiniByte CPU core.
- Converts each CPU step into a multi-phase bus cycle: address latch, strobe with wait states and ready, data capture.
- Gates the CPU's enable so the core advances exactly one step per completed bus cycle.
- Holds read data stable toward the CPU's data input for the step.

---
 rtl/minibyte_bus_pkg.sv | 15 +
 rtl/minibyte_wait_ctr.sv | 25 ++
 rtl/minibyte_bus_ctrl.sv | 142 ++++++++++++++
 tb/tb_minibyte_bus_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minibyte_bus_pkg.sv
// Shared definitions for the MiniByte bus sequencer: FSM state codes and bus constants.
package minibyte_bus_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StWait = 3'd2,
    StData = 3'd3,
    StStep = 3'd4
  } bus_state_e;

  localparam logic [7:0] RD_DEFAULT_VAL = 8'hFF;
  localparam logic [7:0] OE_ALL         = 8'hFF;

endpackage

// File: rtl/minibyte_wait_ctr.sv
// 4-bit loadable down-counter that times the minimum strobe width of a bus cycle.
module minibyte_wait_ctr (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/minibyte_bus_ctrl.sv
// MiniByte bus sequencer: one ADDR/WAIT/DATA/STEP bus cycle per CPU step.
// Define MINIBYTE_BUS_TIMEOUT_EN to build the ready timeout, forced completion and err_out.
module minibyte_bus_ctrl
  import minibyte_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [7:0]  RD_DEFAULT  = RD_DEFAULT_VAL
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ena_in,
  input  logic [7:0] cpu_addr_in,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_we_in,
  input  logic       cpu_drive_in,
  output logic       cpu_ena_out,
  output logic [7:0] cpu_data_out,
  output logic [7:0] bus_addr_out,
  output logic [7:0] bus_data_out,
  input  logic [7:0] bus_data_in,
  output logic [7:0] bus_oe_out,
  output logic       ale_out,
  output logic       rd_n_out,
  output logic       we_n_out,
  input  logic       rdy_in,
  output logic       err_out,
  output logic [7:0] dft_state_out
);

  bus_state_e r_state, w_state_nxt;
  logic       r_wr, r_cpu_ena, r_ale, r_rd_n, r_we_n;
  logic [7:0] r_cpu_data, r_bus_addr, r_bus_data, r_bus_oe;
  logic       w_zero, w_load, w_dec, w_tmo_hit, w_forced;

  if ((WAIT_STATES > 15) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_param_check
    $error("minibyte_bus_ctrl: WAIT_STATES or TIMEOUT out of range");
  end

  assign w_load = (r_state == StAddr);
  assign w_dec  = (r_state == StWait) && !w_zero;

  minibyte_wait_ctr u_wait_ctr (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_load     (w_load),
    .i_load_val (4'(WAIT_STATES)),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

`ifdef MINIBYTE_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_tmo;
  logic       r_forced, r_err;

  // Hit on the TIMEOUT-th stalled cycle, i.e. the one that would make the count reach TIMEOUT.
  assign w_tmo_hit = (r_state == StWait) && w_zero && !rdy_in && (r_tmo == TMO_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_tmo    <= 8'd0;
      r_forced <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == StAddr) begin
        r_tmo    <= 8'd0;
        r_forced <= 1'b0;
      end else if ((r_state == StWait) && w_zero && !rdy_in) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if (w_tmo_hit) begin
        r_forced <= 1'b1;
        r_err    <= 1'b1;
      end
    end
  end

  assign w_forced = r_forced;
  assign err_out  = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign w_forced  = 1'b0;
  assign err_out   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (ena_in) w_state_nxt = StAddr;
      StAddr:  w_state_nxt = StWait;
      StWait:  if (w_zero && (rdy_in || w_tmo_hit)) w_state_nxt = StData;
      StData:  w_state_nxt = StStep;
      StStep:  w_state_nxt = ena_in ? StAddr : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs are decoded from the state being entered so they are valid for that whole state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= StIdle;
      r_wr       <= 1'b0;
      r_cpu_ena  <= 1'b0;
      r_ale      <= 1'b0;
      r_rd_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_cpu_data <= 8'd0;
      r_bus_addr <= 8'd0;
      r_bus_data <= 8'd0;
      r_bus_oe   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ale     <= (w_state_nxt == StAddr);
      r_cpu_ena <= (w_state_nxt == StStep);
      r_rd_n    <= !((w_state_nxt == StWait) && !r_wr);
      r_we_n    <= !((w_state_nxt == StWait) && r_wr);
      r_bus_oe  <= (r_wr && ((w_state_nxt == StWait) || (w_state_nxt == StData))) ? OE_ALL
                                                                                   : 8'd0;
      if (w_state_nxt == StAddr) begin
        r_bus_addr <= cpu_addr_in;
        r_bus_data <= cpu_data_in;
        r_wr       <= cpu_we_in & cpu_drive_in;
      end
      if ((r_state == StData) && !r_wr) begin
        r_cpu_data <= w_forced ? RD_DEFAULT : bus_data_in;
      end
    end
  end

  assign cpu_ena_out   = r_cpu_ena;
  assign cpu_data_out  = r_cpu_data;
  assign bus_addr_out  = r_bus_addr;
  assign bus_data_out  = r_bus_data;
  assign bus_oe_out    = r_bus_oe;
  assign ale_out       = r_ale;
  assign rd_n_out      = r_rd_n;
  assign we_n_out      = r_we_n;
  assign dft_state_out = {5'd0, r_state};

endmodule

// File: tb/tb_minibyte_bus_ctrl.sv
// Self-checking bench for minibyte_bus_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a bus-cycle reference model.
module tb_minibyte_bus_ctrl;

  localparam int unsigned WS     = 1;
  localparam int unsigned TMO    = 4;
  localparam logic [7:0]  RD_DEF = 8'hFF;
`ifdef MINIBYTE_BUS_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in, ena_in, cpu_we_in, cpu_drive_in, rdy_in;
  logic [7:0] cpu_addr_in, cpu_data_in, bus_data_in;
  logic       cpu_ena_out, ale_out, rd_n_out, we_n_out, err_out;
  logic [7:0] cpu_data_out, bus_addr_out, bus_data_out, bus_oe_out, dft_state_out;

  minibyte_bus_ctrl #(
    .WAIT_STATES (WS),
    .TIMEOUT     (TMO),
    .RD_DEFAULT  (RD_DEF)
  ) u_dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .ena_in        (ena_in),
    .cpu_addr_in   (cpu_addr_in),
    .cpu_data_in   (cpu_data_in),
    .cpu_we_in     (cpu_we_in),
    .cpu_drive_in  (cpu_drive_in),
    .cpu_ena_out   (cpu_ena_out),
    .cpu_data_out  (cpu_data_out),
    .bus_addr_out  (bus_addr_out),
    .bus_data_out  (bus_data_out),
    .bus_data_in   (bus_data_in),
    .bus_oe_out    (bus_oe_out),
    .ale_out       (ale_out),
    .rd_n_out      (rd_n_out),
    .we_n_out      (we_n_out),
    .rdy_in        (rdy_in),
    .err_out       (err_out),
    .dft_state_out (dft_state_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference model: phase 0 idle, 1 address, 2 wait, 3 data, 4 step.
  int         ph = 0;
  int         m_wcyc, m_stalls;
  bit         m_wr, m_err, m_forced;
  logic [7:0] m_cpu_data, m_baddr, m_bdata;

  task automatic begin_txn();
    ph       = 1;
    m_baddr  = cpu_addr_in;
    m_bdata  = cpu_data_in;
    m_wr     = cpu_we_in & cpu_drive_in;
    m_forced = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs that edge will sample.
  task automatic model_step();
    if (!rst_in) begin
      ph = 0; m_wr = 1'b0; m_err = 1'b0; m_forced = 1'b0;
      m_cpu_data = 8'd0; m_baddr = 8'd0; m_bdata = 8'd0;
      return;
    end
    case (ph)
      0: if (ena_in) begin_txn();
      1: begin ph = 2; m_wcyc = 0; m_stalls = 0; end
      2: begin
        if (m_wcyc < int'(WS)) m_wcyc++;
        else if (rdy_in) ph = 3;
        else begin
          m_stalls++;
          if (TmoEn && (m_stalls == int'(TMO))) begin
            m_err = 1'b1; m_forced = 1'b1; ph = 3;
          end
        end
      end
      3: begin
        if (!m_wr) m_cpu_data = m_forced ? RD_DEF : bus_data_in;
        ph = 4;
      end
      default: if (ena_in) begin_txn(); else ph = 0;
    endcase
  endtask

  initial begin
    #1 model_step();
    forever begin
      @(negedge clk_in);
      chk("state",    dft_state_out, 8'(ph));
      chk("ale",      8'(ale_out),     8'(ph == 1));
      chk("rd_n",     8'(rd_n_out),    8'(!(ph == 2 && !m_wr)));
      chk("we_n",     8'(we_n_out),    8'(!(ph == 2 && m_wr)));
      chk("oe",       bus_oe_out,      (m_wr && (ph == 2 || ph == 3)) ? 8'hFF : 8'h00);
      chk("cpu_ena",  8'(cpu_ena_out), 8'(ph == 4));
      chk("cpu_data", cpu_data_out,    m_cpu_data);
      chk("bus_addr", bus_addr_out,    m_baddr);
      chk("bus_data", bus_data_out,    m_bdata);
      chk("err",      8'(err_out),     8'(m_err));
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  // Advance until the step pulse is seen; n is the number of edges taken.
  task automatic run_step(output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (cpu_ena_out) seen = 1'b1;
    end
    chk("step_seen", 8'(seen), 8'd1);
  endtask

  initial begin
    int n;
    int rdy_pct;
    rst_in = 1'b0; ena_in = 1'b1; rdy_in = 1'b1;
    cpu_addr_in = 8'h10; cpu_data_in = 8'h00; cpu_we_in = 1'b0; cpu_drive_in = 1'b0;
    bus_data_in = 8'h5A;

    // Reset held with ena_in high.
    repeat (2) tick();
    chk("rst_ale", 8'(ale_out), 8'd0);
    chk("rst_rd_n", 8'(rd_n_out), 8'd1);
    chk("rst_we_n", 8'(we_n_out), 8'd1);
    chk("rst_cpu_ena", 8'(cpu_ena_out), 8'd0);
    chk("rst_oe", bus_oe_out, 8'h00);
    chk("rst_cpu_data", cpu_data_out, 8'h00);
    chk("rst_state", dft_state_out, 8'd0);
    rst_in = 1'b1;
    tick();
    chk("first_ale", 8'(ale_out), 8'd1);
    chk("first_addr", bus_addr_out, 8'h10);

    // Read with one wait state.
    run_step(n);
    chk("read_latency", 8'(n), 8'd4);
    chk("read_data", cpu_data_out, 8'h5A);
    run_step(n);
    chk("read_period", 8'(n), 8'd5);

    // Write leaves cpu_data_out alone.
    cpu_we_in = 1'b1; cpu_drive_in = 1'b1; cpu_data_in = 8'hC3; bus_data_in = 8'h77;
    run_step(n);
    chk("write_period", 8'(n), 8'd5);
    chk("write_bus_data", bus_data_out, 8'hC3);
    chk("write_cpu_data", cpu_data_out, 8'h5A);

    // Ready withheld for three cycles past the wait count.
    cpu_we_in = 1'b0; cpu_drive_in = 1'b0; rdy_in = 1'b0;
    repeat (6) tick();
    rdy_in = 1'b1;
    run_step(n);
    chk("stall_period", 8'(6 + n), 8'd8);
    chk("stall_err", 8'(err_out), 8'd0);

    // Ready never arrives.
    bus_data_in = 8'h3C; rdy_in = 1'b0;
`ifdef MINIBYTE_BUS_TIMEOUT_EN
    run_step(n);
    chk("tmo_period", 8'(n), 8'd8);
    chk("tmo_err", 8'(err_out), 8'd1);
    chk("tmo_data", cpu_data_out, 8'hFF);
    rdy_in = 1'b1;
`else
    repeat (10) tick();
    chk("hold_state", dft_state_out, 8'd2);
    chk("hold_err", 8'(err_out), 8'd0);
    rdy_in = 1'b1;
    run_step(n);
    chk("hold_data", cpu_data_out, 8'h3C);
`endif

    // Normal cycle afterwards; err_out is sticky.
    bus_data_in = 8'h96;
    run_step(n);
    chk("after_period", 8'(n), 8'd5);
    chk("after_data", cpu_data_out, 8'h96);
    chk("err_sticky", 8'(err_out), 8'(TmoEn));

    // ena_in dropped mid-cycle: cycle completes with its pulse, then idle.
    tick(); tick();
    ena_in = 1'b0;
    run_step(n);
    chk("drop_len", 8'(n), 8'd3);
    tick();
    chk("drop_idle", dft_state_out, 8'd0);
    repeat (3) tick();
    chk("drop_still_idle", dft_state_out, 8'd0);

    // Reset during WAIT.
    ena_in = 1'b1;
    tick(); tick();
    chk("pre_rst_rd_n", 8'(rd_n_out), 8'd0);
    rst_in = 1'b0;
    tick();
    chk("rst_wait_state", dft_state_out, 8'd0);
    chk("rst_wait_rd_n", 8'(rd_n_out), 8'd1);
    chk("rst_wait_ena", 8'(cpu_ena_out), 8'd0);
    rst_in = 1'b1;

    // Randomized traffic with varying ready density.
    rdy_pct = 90;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 64) == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 90;
          1:       rdy_pct = 50;
          default: rdy_pct = 10;
        endcase
      end
      tick();
      rst_in       = ($urandom_range(0, 199) != 0);
      ena_in       = ($urandom_range(0, 9) != 0);
      rdy_in       = ($urandom_range(0, 99) < rdy_pct);
      cpu_addr_in  = 8'($urandom);
      cpu_data_in  = 8'($urandom);
      bus_data_in  = 8'($urandom);
      cpu_we_in    = 1'($urandom);
      cpu_drive_in = 1'($urandom);
    end
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
